// File: rtl/demux_1_8_scheduler_if.sv
// demux_1_8_scheduler_if: upstream handshake, channel requests and demux drive bundle
interface demux_1_8_scheduler_if;
  logic       Data_In;
  logic       Data_Valid_In;
  logic       Data_Ready_Out;
  logic [7:0] Channel_Req_In;
  logic [7:0] Grant_Out;
  logic [2:0] Select_Out;
  logic       Enable_Out;
  logic       Data_Out;
  logic       Burst_Done_Out;
  logic       Busy_Out;
  modport master (
    output Data_In, Data_Valid_In, Channel_Req_In,
    input  Data_Ready_Out, Grant_Out, Select_Out, Enable_Out, Data_Out, Burst_Done_Out, Busy_Out
  );
  modport slave (
    input  Data_In, Data_Valid_In, Channel_Req_In,
    output Data_Ready_Out, Grant_Out, Select_Out, Enable_Out, Data_Out, Burst_Done_Out, Busy_Out
  );
endinterface

// File: rtl/demux_1_8_scheduler.sv
// demux_1_8_scheduler: round-robin burst scheduler feeding one serial stream to a 1:8 demux
module demux_1_8_scheduler #(
  parameter int BURST_LEN = 4
) (
  input logic                    Clock_In,
  input logic                    Reset_In,
  demux_1_8_scheduler_if.slave   bus
);
  typedef enum logic {IDLE, XFER} state_t;
  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);
  state_t     state_q;
  logic [2:0] last_ch_q, select_q, winner;
  logic [3:0] beat_cnt_q;
  logic [7:0] grant_q;
  logic       enable_q, data_q, done_q, accept, burst_end;
  // Later offsets overwrite earlier ones, so the nearest requester after last_ch_q wins.
  always_comb begin
    winner = last_ch_q;
    for (int k = 8; k >= 1; k--)
      if (bus.Channel_Req_In[3'(last_ch_q + 3'(k))]) winner = 3'(last_ch_q + 3'(k));
  end
  assign accept    = (state_q == XFER) && bus.Data_Valid_In;
  assign burst_end = (state_q == XFER) &&
                     ((accept && beat_cnt_q == LAST_BEAT) || !bus.Channel_Req_In[last_ch_q]);
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q    <= IDLE;
      last_ch_q  <= 3'd7;
      beat_cnt_q <= '0;
      select_q   <= '0;
      grant_q    <= '0;
      enable_q   <= 1'b0;
      data_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      enable_q <= accept;
      done_q   <= burst_end;
      if (accept) begin
        data_q     <= bus.Data_In;
        beat_cnt_q <= beat_cnt_q + 4'd1;
      end
      if (state_q == IDLE) begin
        if (|bus.Channel_Req_In) begin
          state_q    <= XFER;
          select_q   <= winner;
          grant_q    <= 8'd1 << winner;
          last_ch_q  <= winner;
          beat_cnt_q <= '0;
        end
      end else if (burst_end) begin
        state_q <= IDLE;
        grant_q <= '0;
      end
    end
  end
  assign bus.Data_Ready_Out = (state_q == XFER);
  assign bus.Busy_Out       = (state_q == XFER);
  assign bus.Grant_Out      = grant_q;
  assign bus.Select_Out     = select_q;
  assign bus.Enable_Out     = enable_q;
  assign bus.Data_Out       = data_q;
  assign bus.Burst_Done_Out = done_q;
endmodule
